fpu_vadd_sequencer: RTL and testbench
=====================================

Name: fpu_vadd_sequencer

Overview:
Sequences one shared combinational FP32 adder across the lanes of a vector add/subtract instruction in the vector FPU. It captures both operand vectors on a start handshake and feeds one lane per cycle to the adder through its A/B/O interface. It registers each lane result and signals completion with a one-cycle done pulse. The adder instance sits outside this block; this block only drives it and collects its output.

Parameters:
LANES, 4, number of vector lanes processed per instruction (>=1)
WIDTH, 32, element width in bits (IEEE-754 single; sign is bit WIDTH-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
op_sub  input  1  1 = A-B, 0 = A+B; sampled with start
lane_mask  input  LANES  1 = lane active; sampled with start
vec_a  input  LANES*WIDTH  operand A vector, lane i at [i*WIDTH +: WIDTH]
vec_b  input  LANES*WIDTH  operand B vector, same packing
ready  output  1  high in IDLE only
busy  output  1  high from accepted start until done pulse inclusive
done  output  1  one-cycle completion pulse
result  output  LANES*WIDTH  registered result vector, same packing
add_a  output  WIDTH  to adder input A
add_b  output  WIDTH  to adder input B
add_o  input  WIDTH  from adder output O (combinational, same cycle)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lane index=0, result=0, done=0, busy=0, ready=1, operand/mask/op registers=0, add_a=add_b=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: ready=1. If start=1 at a clock edge, register vec_a, vec_b, lane_mask, op_sub; lane index<=0; go RUN. start while not in IDLE is ignored (no queuing).
- RUN: add_a = captured A[idx]; add_b = captured B[idx] with bit WIDTH-1 inverted if op_sub=1. On each edge, result[idx] <= add_o if mask[idx]=1, else result[idx] <= A[idx] (passthrough, no sign flip). idx increments; after idx=LANES-1 is written, go DONE.
- Every lane costs one cycle regardless of mask, so latency is fixed.
- DONE: done=1 for exactly one cycle; busy=1; then IDLE. A start asserted during DONE is ignored; it is accepted the following cycle.
- Latency: start edge at cycle 0 -> done high during cycle LANES+1. Back-to-back throughput is one instruction every LANES+2 cycles.
- In IDLE and DONE, add_a and add_b are driven to 0.
- result changes only on lane writes. It holds the last instruction's value until lanes are overwritten by the next instruction. Lanes not yet processed keep their old values mid-instruction.
- Input vectors may change freely after acceptance; only captured copies are used.
- LANES=1: RUN lasts one cycle; done is high during cycle 2.
- rst_n low mid-RUN: immediate return to reset values; no done pulse; partial results are discarded (result=0).
- No exception or rounding handling here; this block passes whatever the adder returns.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> ready=1, busy=0, done=0, result=0. Release -> first start accepted next edge.
- Add, all lanes active: every lane A=0x41200000, B=0x41200000, op_sub=0, mask=4'b1111 -> done in cycle 5; every lane result=0x41A00000.
- Subtract via sign flip: lane0 A=0x41700000, B=0x41200000, op_sub=1 -> add_b observed 0xC1200000 in lane0 cycle; result lane0=0x40A00000.
- Mixed lanes plus mask: lane2 A=0x4640E400, B=0x46A05800; lane1 A=0x3F800000; mask=4'b0101 -> lane2=0x47006500, lane1=0x3F800000 passthrough; done still in cycle 5.
- Protocol: pulse start during RUN and during DONE -> ignored, with exactly one done pulse. Start held high continuously -> back-to-back instructions accepted every 6 cycles (LANES=4).
- Mid-op reset: assert rst_n=0 at lane 2 of RUN -> result=0, busy=0, no done. The next instruction completes normally.

Source files
------------

// File: rtl/fpu_vadd_sequencer_if.sv
// Connection between the vector add sequencer and the shared combinational
// FP32 adder. The sequencer drives the operands and the adder returns the sum
// in the same cycle.
interface fpu_vadd_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_o;

  modport master (output add_a, output add_b, input add_o);
  modport slave  (input add_a, input add_b, output add_o);
endinterface

// File: rtl/fpu_vadd_sequencer.sv
// Vector add/subtract sequencer. It time-shares one external combinational
// FP32 adder across LANES lanes, one lane per cycle, and collects the results.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | ready for a new instruction; adder inputs held at zero
//   RUN   | lane idx on the adder; its result is written on the next edge
//   DONE  | one-cycle completion pulse; new starts are ignored here
module fpu_vadd_sequencer #(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   op_sub_i,
  input  logic [LANES-1:0]       lane_mask_i,
  input  logic [LANES*WIDTH-1:0] vec_a_i,
  input  logic [LANES*WIDTH-1:0] vec_b_i,
  output logic                   ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LANES*WIDTH-1:0] result_o,
  fpu_vadd_sequencer_if.master   add_if
);

  localparam int               IDX_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LANES*WIDTH-1:0] a_q, b_q;
  logic [LANES-1:0]       mask_q;
  logic                   sub_q;
  logic [LANES*WIDTH-1:0] result_q, result_d;
  logic                   capture;
  logic [WIDTH-1:0]       lane_a, lane_b;
  logic                   lane_m;

  // State and lane index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand capture on an accepted start; inputs are free to change afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mask_q <= '0;
      sub_q  <= 1'b0;
    end else if (capture) begin
      a_q    <= vec_a_i;
      b_q    <= vec_b_i;
      mask_q <= lane_mask_i;
      sub_q  <= op_sub_i;
    end
  end

  // Result vector; reset discards partial results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  // Next-state logic and status outputs
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Select the captured operands and mask bit of the current lane
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    lane_m = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        lane_a = a_q[i*WIDTH +: WIDTH];
        lane_b = b_q[i*WIDTH +: WIDTH];
        lane_m = mask_q[i];
      end
    end
  end

  // Drive the adder only while running; subtraction is a sign flip on B
  always_comb begin
    add_if.add_a = '0;
    add_if.add_b = '0;
    if (state_q == RUN) begin
      add_if.add_a = lane_a;
      add_if.add_b = sub_q ? (lane_b ^ SIGN_BIT) : lane_b;
    end
  end

  // Lane write: adder sum for active lanes, unmodified A for masked-off lanes
  always_comb begin
    result_d = result_q;
    if (state_q == RUN) begin
      for (int i = 0; i < LANES; i++) begin
        if (idx_q == IDX_W'(i)) begin
          result_d[i*WIDTH +: WIDTH] = lane_m ? add_if.add_o : lane_a;
        end
      end
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_fpu_vadd_sequencer.sv
// Bench for fpu_vadd_sequencer: behavioural adder on the interface, scoreboard
// of expected result vectors checked on every done pulse.
module tb_fpu_vadd_sequencer;

  localparam int LANES = 4;
  localparam int WIDTH = 32;
  localparam int VW    = LANES * WIDTH;
  localparam logic [WIDTH-1:0] SIGN = 32'h8000_0000;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op_sub;
  logic [LANES-1:0] lane_mask;
  logic [VW-1:0]    vec_a;
  logic [VW-1:0]    vec_b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [VW-1:0]    result;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int exp_done = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] exp_prev;
  logic [VW-1:0] mon_exp;

  fpu_vadd_sequencer_if #(.WIDTH(WIDTH)) add_if ();

  fpu_vadd_sequencer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .op_sub_i    (op_sub),
    .lane_mask_i (lane_mask),
    .vec_a_i     (vec_a),
    .vec_b_i     (vec_b),
    .ready_o     (ready),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .add_if      (add_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the external adder: exact FP sums for the directed vectors,
  // integer sum otherwise (the sequencer only forwards what it gets).
  function automatic logic [WIDTH-1:0] fadd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a == 32'h4120_0000 && b == 32'h4120_0000) return 32'h41A0_0000;
    if (a == 32'h4170_0000 && b == 32'hC120_0000) return 32'h40A0_0000;
    if (a == 32'h4640_E400 && b == 32'h46A0_5800) return 32'h4700_6500;
    return a + b;
  endfunction

  assign add_if.add_o = fadd(add_if.add_a, add_if.add_b);

  function automatic logic [VW-1:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                          input logic [LANES-1:0] m, input logic sub);
    logic [VW-1:0]    r;
    logic [WIDTH-1:0] ai, bi;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      ai = a[i*WIDTH +: WIDTH];
      bi = b[i*WIDTH +: WIDTH] ^ (sub ? SIGN : '0);
      r[i*WIDTH +: WIDTH] = m[i] ? fadd(ai, bi) : ai;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each done pulse retires the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("done_without_instr", VW'(done), VW'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", result, mon_exp);
      end
    end
  end

  // Issue one instruction from a negedge and follow it to IDLE
  task automatic run_instr(input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input logic [LANES-1:0] m, input logic sub, input bit poke);
    logic [VW-1:0]    e;
    logic [WIDTH-1:0] ea, eb;
    start     = 1'b1;
    vec_a     = a;
    vec_b     = b;
    lane_mask = m;
    op_sub    = sub;
    chk("ready_before_start", VW'(ready), VW'(1));
    @(posedge clk);
    e = model(a, b, m, sub);
    exp_q.push_back(e);
    exp_done++;
    #1;
    start     = 1'b0;
    vec_a     = ~a;
    vec_b     = ~b;
    lane_mask = ~m;
    op_sub    = ~sub;
    for (int i = 0; i < LANES; i++) begin
      @(negedge clk);
      ea = a[i*WIDTH +: WIDTH];
      eb = b[i*WIDTH +: WIDTH] ^ (sub ? SIGN : '0);
      chk($sformatf("add_a_lane%0d", i), VW'(add_if.add_a), VW'(ea));
      chk($sformatf("add_b_lane%0d", i), VW'(add_if.add_b), VW'(eb));
      chk($sformatf("status_run%0d", i), VW'({ready, busy, done}), VW'(3'b010));
      if (i == 0) chk("result_hold_prev", result, exp_prev);
      if (poke && i == 1) start = 1'b1;
      if (poke && i == 2) start = 1'b0;
    end
    @(negedge clk);
    chk("status_done", VW'({ready, busy, done}), VW'(3'b011));
    chk("adder_idle_in_done", VW'({add_if.add_a, add_if.add_b}), VW'(0));
    exp_prev = e;
    if (poke) start = 1'b1;
    @(negedge clk);
    chk("status_idle_after", VW'({ready, busy, done}), VW'(3'b100));
    start = 1'b0;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = $urandom();
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] a, b, a2, b2, e2;
    int cnt;

    exp_prev  = '0;
    rst_n     = 1'b0;
    start     = 1'b1;
    op_sub    = 1'b0;
    lane_mask = 4'b1111;
    vec_a     = {4{32'h4120_0000}};
    vec_b     = {4{32'h4120_0000}};

    // Reset held with start asserted
    repeat (3) @(negedge clk);
    chk("reset_status", VW'({ready, busy, done}), VW'(3'b100));
    chk("reset_result", result, VW'(0));
    chk("reset_adder", VW'({add_if.add_a, add_if.add_b}), VW'(0));
    rst_n = 1'b1;

    // Add, all lanes active; start still high so it is taken on the first edge
    run_instr({4{32'h4120_0000}}, {4{32'h4120_0000}}, 4'b1111, 1'b0, 1'b0);

    // Subtract by sign flip on lane 0
    a = {32'd300, 32'd200, 32'd100, 32'h4170_0000};
    b = {32'd3,   32'd2,   32'd1,   32'h4120_0000};
    run_instr(a, b, 4'b1111, 1'b1, 1'b0);

    // Mixed lanes with mask 0101: lanes 1 and 3 pass A through
    a = {32'hBF80_0000, 32'h4640_E400, 32'h3F80_0000, 32'h4120_0000};
    b = {32'h1234_5678, 32'h46A0_5800, 32'h4000_0000, 32'h4120_0000};
    run_instr(a, b, 4'b0101, 1'b0, 1'b0);

    // Starts pulsed during RUN and during DONE must be ignored
    run_instr(rand_vec(), rand_vec(), 4'b1011, 1'b1, 1'b1);

    // Random instructions
    for (int k = 0; k < 4; k++) begin
      run_instr(rand_vec(), rand_vec(), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'b0);
    end

    // Start held high: back-to-back acceptance every LANES+2 cycles
    a  = rand_vec();
    b  = rand_vec();
    a2 = rand_vec();
    b2 = rand_vec();
    start     = 1'b1;
    vec_a     = a;
    vec_b     = b;
    lane_mask = 4'b1110;
    op_sub    = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(a, b, 4'b1110, 1'b0));
    exp_done++;
    #1;
    vec_a     = a2;
    vec_b     = b2;
    lane_mask = 4'b0111;
    op_sub    = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!ready && cnt < 20);
    chk("b2b_interval", VW'(cnt), VW'(LANES + 2));
    @(posedge clk);
    e2 = model(a2, b2, 4'b0111, 1'b1);
    exp_q.push_back(e2);
    exp_done++;
    #1 start = 1'b0;
    repeat (LANES + 1) @(negedge clk);
    chk("b2b_done", VW'(done), VW'(1));
    @(negedge clk);
    chk("b2b_idle", VW'({ready, busy, done}), VW'(3'b100));
    exp_prev = e2;

    // Reset during lane 2 of RUN
    start     = 1'b1;
    vec_a     = rand_vec();
    vec_b     = rand_vec();
    lane_mask = 4'b1111;
    op_sub    = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(vec_a, vec_b, 4'b1111, 1'b0));
    exp_done++;
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_done--;
    exp_prev = '0;
    #1;
    chk("midreset_result", result, VW'(0));
    chk("midreset_status", VW'({ready, busy, done}), VW'(3'b100));
    chk("midreset_adder", VW'({add_if.add_a, add_if.add_b}), VW'(0));
    repeat (LANES + 2) @(negedge clk);
    chk("midreset_no_done", VW'(done), VW'(0));
    rst_n = 1'b1;
    run_instr({4{32'h4120_0000}}, {32'd7, 32'd6, 32'd5, 32'h4120_0000}, 4'b1101, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", VW'(exp_q.size()), VW'(0));
    chk("done_count", VW'(done_cnt), VW'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
